data_frame_parser: RTL
======================

Name: data_frame_parser

Overview:
- Receiving end of the per-channel 64-bit data-frame stream: header word, N data words, footer word.
- Sits downstream of the channel merger, on the host/DMA side.
- Validates framing, strips header and footer, forwards the data words with a last-word marker, and publishes per-frame metadata through a one-entry info register.
- Unframed or malformed input is dropped and reported, never forwarded.

Parameters:
- DATA_WIDTH, 64, frame word width (fixed; other values unsupported).
- MAX_FRAME_LENGTH, 200, largest legal data-word count per frame. Effective limit is ACTUAL_MAX = (MAX_FRAME_LENGTH/2)*2.
- FRAME_LEN_WIDTH, 10, width of header length field, bits [FRAME_LEN_WIDTH-1:0].
- ADC_RESOLUTION_WIDTH, 12, baseline width; threshold width is this +1.
- TIME_STAMP_WIDTH, 48, reassembled timestamp width.
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- CLK  in  1  sole clock.
- RESETN  in  1  asynchronous active-low reset.
- DIN  in  64  input frame word.
- iVALID  in  1  DIN valid.
- oREADY  out  1  DIN accepted when iVALID&oREADY.
- DOUT  out  64  forwarded data word.
- oVALID  out  1  DOUT valid.
- oLAST  out  1  DOUT is last data word of frame.
- iREADY  in  1  downstream accepts DOUT.
- INFO_VALID  out  1  frame metadata valid.
- INFO_READY  in  1  metadata consumed.
- INFO_CH_ID  out  4  channel ID.
- INFO_TIME_STAMP  out  48  {footer[31:16], header[43:12]}.
- INFO_LEN  out  FRAME_LEN_WIDTH  data-word count.
- INFO_BASELINE  out  ADC_RESOLUTION_WIDTH  footer[63:48] low bits.
- INFO_THRESHOLD  out  ADC_RESOLUTION_WIDTH+1  footer[47:32] low bits.
- INFO_FTR_ERR  out  1  footer ID mismatch for this frame.
- ERR_PULSE  out  3  one-cycle flags {FTR, LEN, HDR}.
- FRAME_CNT  out  CNT_WIDTH  completed frames, saturating.
- DROP_CNT  out  CNT_WIDTH  dropped words, saturating.

Behaviour:
- Frame format:
  - Header: [63:48]=0xAAAA, [47:44] ch, [43:12] first 32 timestamp bits, [FRAME_LEN_WIDTH-1:0] length; bits [11:FRAME_LEN_WIDTH] ignored.
  - Footer: [63:48] baseline (sign-extended), [47:32] threshold (sign-extended), [31:16] upper 16 timestamp bits, [15:0]=0x5555.
- Reset values: all outputs 0 and state HUNT, applied asynchronously. A reset mid-frame discards the partial frame with no info emitted.
- FSM states: HUNT, DATA, FOOTER.
- HUNT:
  - oREADY=1.
  - Accepted word with ID 0xAAAA and length nonzero, even and <= ACTUAL_MAX: latch ch/ts/len, remaining<=len, go to DATA.
  - ID match but illegal length: ERR_PULSE[1]; word dropped; stay in HUNT.
  - ID mismatch: drop the word; ERR_PULSE[0] only on the first word of a consecutive drop run.
  - DROP_CNT increments on every dropped word.
- DATA:
  - Output is a valid/ready register stage. oREADY = !oVALID | iREADY.
  - Each accepted word is loaded into DOUT the next cycle and remaining decrements. oLAST=1 when remaining==1, then go to FOOTER.
  - Words carrying 0xAAAA in DATA are data; there is no resync mid-frame.
  - Throughput is 1 word/cycle with iREADY held high; latency DIN->DOUT is 1 cycle.
  - DOUT/oVALID/oLAST hold while oVALID&!iREADY.
- FOOTER:
  - oREADY = !INFO_VALID | INFO_READY.
  - Accepted word loads the info register with INFO_VALID=1 and INFO_FTR_ERR=(footer[15:0]!=0x5555). On mismatch also pulse ERR_PULSE[2].
  - FRAME_CNT increments either way; go to HUNT.
  - Load coinciding with INFO_READY: new contents replace old and INFO_VALID stays 1.
- INFO_VALID clears on INFO_READY when no load occurs in the same cycle.
- Counters saturate at all-ones and never wrap.
- Stall with iVALID=0 in any state: state and remaining are held.

Decomposition:
- Shared package data_frame_pkg holds:
  - HEADER_ID=16'hAAAA, FOOTER_ID=16'h5555.
  - Field bit positions.
  - State encoding {HUNT, DATA, FOOTER}.
  - ERR_PULSE bit indices.
- One natural sub-module, frame_word_reg_slice: single-entry valid/ready output register carrying DOUT and oLAST.

Test Plan:
- Legal frame, header len=4, DIN ts 0x1234_5678, footer [31:16]=0x0ABC, all ready=1 -> 4 DOUT words in order, oLAST on the 4th; INFO_TIME_STAMP=0x0ABC_1234_5678, INFO_LEN=4, FRAME_CNT=1.
- Three garbage words, then a legal len=2 frame -> ERR_PULSE[0] once; DROP_CNT=3; frame forwarded intact.
- Header len=0 and header len=3 -> ERR_PULSE[1] each; no DOUT; state remains HUNT.
- Footer low half 0x1234 -> INFO_VALID with INFO_FTR_ERR=1; ERR_PULSE[2]; next header parsed normally.
- iREADY toggling 1/0 during len=8 data, and INFO_READY=0 with two back-to-back frames:
  - DOUT stable while stalled and no word lost.
  - Second footer blocks (oREADY=0) until INFO_READY.
- RESETN low mid-DATA, then a new len=2 frame -> outputs 0 immediately; no info for the aborted frame; new frame correct.

Source files
------------

// File: rtl/data_frame_pkg.sv
// Shared definitions for the data-frame parser: frame IDs, field positions,
// parser state encoding and error-pulse bit indices.
package data_frame_pkg;

    localparam logic [15:0] HEADER_ID = 16'hAAAA;
    localparam logic [15:0] FOOTER_ID = 16'h5555;

    localparam int ID_W         = 16;
    localparam int HDR_ID_LSB   = 48;
    localparam int HDR_CH_LSB   = 44;
    localparam int HDR_CH_W     = 4;
    localparam int HDR_TS_LSB   = 12;
    localparam int HDR_TS_W     = 32;
    localparam int FTR_BASE_LSB = 48;
    localparam int FTR_THR_LSB  = 32;
    localparam int FTR_TS_LSB   = 16;
    localparam int FTR_TS_W     = 16;
    localparam int FTR_ID_LSB   = 0;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_DATA   = 2'd1,
        ST_FOOTER = 2'd2
    } state_t;

    localparam int ERR_HDR = 0;
    localparam int ERR_LEN = 1;
    localparam int ERR_FTR = 2;

    // A usable frame carries a nonzero, even word count no larger than the limit.
    function automatic logic len_is_legal(input logic [15:0] len, input int unsigned max_len);
        return (len != 16'd0) && (len[0] == 1'b0) && (32'(len) <= max_len);
    endfunction

endpackage

// File: rtl/frame_word_reg_slice.sv
// Single-entry valid/ready output register holding one data word and its
// last-word marker; accepts a new word whenever empty or being drained.
module frame_word_reg_slice #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_last,
    input  logic                  i_ready,
    output logic                  o_space,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_last
);

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_last;

    assign o_space = !r_valid || i_ready;

    // Output word register: load, drain, or hold while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_last  <= i_last;
        end else if (i_ready) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_valid <= r_valid;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_last;

endmodule

// File: rtl/data_frame_parser.sv
// Frame parser: hunts for a legal header, forwards the data words through an
// output register stage, and publishes per-frame metadata on the footer.
module data_frame_parser
    import data_frame_pkg::*;
#(
    parameter int DATA_WIDTH           = 64,
    parameter int MAX_FRAME_LENGTH     = 200,
    parameter int FRAME_LEN_WIDTH      = 10,
    parameter int ADC_RESOLUTION_WIDTH = 12,
    parameter int TIME_STAMP_WIDTH     = 48,
    parameter int CNT_WIDTH            = 16
) (
    input  logic                            CLK,
    input  logic                            RESETN,
    input  logic [DATA_WIDTH-1:0]           DIN,
    input  logic                            iVALID,
    output logic                            oREADY,
    output logic [DATA_WIDTH-1:0]           DOUT,
    output logic                            oVALID,
    output logic                            oLAST,
    input  logic                            iREADY,
    output logic                            INFO_VALID,
    input  logic                            INFO_READY,
    output logic [3:0]                      INFO_CH_ID,
    output logic [TIME_STAMP_WIDTH-1:0]     INFO_TIME_STAMP,
    output logic [FRAME_LEN_WIDTH-1:0]      INFO_LEN,
    output logic [ADC_RESOLUTION_WIDTH-1:0] INFO_BASELINE,
    output logic [ADC_RESOLUTION_WIDTH:0]   INFO_THRESHOLD,
    output logic                            INFO_FTR_ERR,
    output logic [2:0]                      ERR_PULSE,
    output logic [CNT_WIDTH-1:0]            FRAME_CNT,
    output logic [CNT_WIDTH-1:0]            DROP_CNT
);

    localparam int unsigned ACTUAL_MAX = (MAX_FRAME_LENGTH / 2) * 2;
    localparam logic [FRAME_LEN_WIDTH-1:0] LEN_ONE = {{(FRAME_LEN_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]       CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]       CNT_MAX = {CNT_WIDTH{1'b1}};

    state_t                            r_state;
    state_t                            w_state_nxt;
    logic [FRAME_LEN_WIDTH-1:0]        r_remaining;
    logic [HDR_CH_W-1:0]               r_hdr_ch;
    logic [HDR_TS_W-1:0]               r_hdr_ts;
    logic [FRAME_LEN_WIDTH-1:0]        r_hdr_len;
    logic                              r_drop_run;
    logic                              r_info_valid;
    logic [3:0]                        r_info_ch;
    logic [TIME_STAMP_WIDTH-1:0]       r_info_ts;
    logic [FRAME_LEN_WIDTH-1:0]        r_info_len;
    logic [ADC_RESOLUTION_WIDTH-1:0]   r_info_base;
    logic [ADC_RESOLUTION_WIDTH:0]     r_info_thr;
    logic                              r_info_ftr_err;
    logic [2:0]                        r_err;
    logic [CNT_WIDTH-1:0]              r_frame_cnt;
    logic [CNT_WIDTH-1:0]              r_drop_cnt;

    logic                              w_din_ready;
    logic                              w_hdr_ok;
    logic                              w_hdr_badlen;
    logic                              w_hdr_drop;
    logic                              w_slice_load;
    logic                              w_slice_space;
    logic                              w_info_load;
    logic [2:0]                        w_err_nxt;
    logic [ID_W-1:0]                   w_din_id;
    logic [FRAME_LEN_WIDTH-1:0]        w_din_len;
    logic                              w_len_ok;
    logic                              w_ftr_bad;
    logic                              w_slice_last;

    assign w_din_id     = DIN[HDR_ID_LSB +: ID_W];
    assign w_din_len    = DIN[FRAME_LEN_WIDTH-1:0];
    assign w_len_ok     = len_is_legal(16'(w_din_len), ACTUAL_MAX);
    assign w_ftr_bad    = (DIN[FTR_ID_LSB +: ID_W] != FOOTER_ID);
    assign w_slice_last = (r_remaining == LEN_ONE);

    // Parser state register.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_state <= ST_HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and per-word actions for the accepted input word.
    always_comb begin
        w_state_nxt  = r_state;
        w_din_ready  = 1'b0;
        w_hdr_ok     = 1'b0;
        w_hdr_badlen = 1'b0;
        w_hdr_drop   = 1'b0;
        w_slice_load = 1'b0;
        w_info_load  = 1'b0;
        case (r_state)
            ST_HUNT: begin
                w_din_ready = 1'b1;
                if (iVALID) begin
                    if (w_din_id != HEADER_ID) begin
                        w_hdr_drop = 1'b1;
                    end else if (w_len_ok) begin
                        w_hdr_ok    = 1'b1;
                        w_state_nxt = ST_DATA;
                    end else begin
                        w_hdr_badlen = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_HUNT;
                end
            end
            ST_DATA: begin
                w_din_ready = w_slice_space;
                if (iVALID && w_slice_space) begin
                    w_slice_load = 1'b1;
                    if (w_slice_last) begin
                        w_state_nxt = ST_FOOTER;
                    end else begin
                        w_state_nxt = ST_DATA;
                    end
                end else begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_FOOTER: begin
                w_din_ready = !r_info_valid || INFO_READY;
                if (iVALID && w_din_ready) begin
                    w_info_load = 1'b1;
                    w_state_nxt = ST_HUNT;
                end else begin
                    w_state_nxt = ST_FOOTER;
                end
            end
            default: begin
                w_state_nxt = ST_HUNT;
            end
        endcase
    end

    // Only the first word of a run of unframed words raises the header error.
    always_comb begin
        w_err_nxt          = 3'b000;
        w_err_nxt[ERR_HDR] = w_hdr_drop && !r_drop_run;
        w_err_nxt[ERR_LEN] = w_hdr_badlen;
        w_err_nxt[ERR_FTR] = w_info_load && w_ftr_bad;
    end

    // Header fields, remaining-word count and drop-run tracking.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_remaining <= '0;
            r_hdr_ch    <= '0;
            r_hdr_ts    <= '0;
            r_hdr_len   <= '0;
            r_drop_run  <= 1'b0;
        end else begin
            if (w_hdr_ok) begin
                r_remaining <= w_din_len;
                r_hdr_ch    <= DIN[HDR_CH_LSB +: HDR_CH_W];
                r_hdr_ts    <= DIN[HDR_TS_LSB +: HDR_TS_W];
                r_hdr_len   <= w_din_len;
            end else if (w_slice_load) begin
                r_remaining <= r_remaining - LEN_ONE;
            end else begin
                r_remaining <= r_remaining;
            end
            if (w_hdr_drop) begin
                r_drop_run <= 1'b1;
            end else if (w_hdr_ok || w_hdr_badlen) begin
                r_drop_run <= 1'b0;
            end else begin
                r_drop_run <= r_drop_run;
            end
        end
    end

    // Metadata register: a load wins over a same-cycle consume.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_info_valid   <= 1'b0;
            r_info_ch      <= '0;
            r_info_ts      <= '0;
            r_info_len     <= '0;
            r_info_base    <= '0;
            r_info_thr     <= '0;
            r_info_ftr_err <= 1'b0;
        end else if (w_info_load) begin
            r_info_valid   <= 1'b1;
            r_info_ch      <= r_hdr_ch;
            r_info_ts      <= {DIN[FTR_TS_LSB +: FTR_TS_W], r_hdr_ts};
            r_info_len     <= r_hdr_len;
            r_info_base    <= DIN[FTR_BASE_LSB +: ADC_RESOLUTION_WIDTH];
            r_info_thr     <= DIN[FTR_THR_LSB +: ADC_RESOLUTION_WIDTH+1];
            r_info_ftr_err <= w_ftr_bad;
        end else if (INFO_READY) begin
            r_info_valid <= 1'b0;
        end else begin
            r_info_valid <= r_info_valid;
        end
    end

    // Error pulses and saturating statistics counters.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_err       <= 3'b000;
            r_frame_cnt <= '0;
            r_drop_cnt  <= '0;
        end else begin
            r_err <= w_err_nxt;
            if (w_info_load && (r_frame_cnt != CNT_MAX)) begin
                r_frame_cnt <= r_frame_cnt + CNT_ONE;
            end else begin
                r_frame_cnt <= r_frame_cnt;
            end
            if ((w_hdr_drop || w_hdr_badlen) && (r_drop_cnt != CNT_MAX)) begin
                r_drop_cnt <= r_drop_cnt + CNT_ONE;
            end else begin
                r_drop_cnt <= r_drop_cnt;
            end
        end
    end

    frame_word_reg_slice #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_slice (
        .clk     (CLK),
        .rst_n   (RESETN),
        .i_load  (w_slice_load),
        .i_data  (DIN),
        .i_last  (w_slice_last),
        .i_ready (iREADY),
        .o_space (w_slice_space),
        .o_valid (oVALID),
        .o_data  (DOUT),
        .o_last  (oLAST)
    );

    // Nothing is accepted while reset is held.
    assign oREADY          = RESETN && w_din_ready;
    assign INFO_VALID      = r_info_valid;
    assign INFO_CH_ID      = r_info_ch;
    assign INFO_TIME_STAMP = r_info_ts;
    assign INFO_LEN        = r_info_len;
    assign INFO_BASELINE   = r_info_base;
    assign INFO_THRESHOLD  = r_info_thr;
    assign INFO_FTR_ERR    = r_info_ftr_err;
    assign ERR_PULSE       = r_err;
    assign FRAME_CNT       = r_frame_cnt;
    assign DROP_CNT        = r_drop_cnt;

endmodule
